// File: rtl/uop_pkg.sv
// Micro-op tag encodings shared by rename, the emit queue and dispatch.
// is_solo_uop() is the single definition of uops that must issue alone.
package uop_pkg;

    typedef logic [3:0] uop_tag_t;

    localparam uop_tag_t UOP_INT_ALU          = 4'd0;
    localparam uop_tag_t UOP_LD_U8            = 4'd1;
    localparam uop_tag_t UOP_ST_U8            = 4'd2;
    localparam uop_tag_t UOP_INT_MUL          = 4'd3;
    localparam uop_tag_t UOP_CAP_FENCE_PREFIX = 4'd4;
    localparam uop_tag_t UOP_CAP_LOAN_BEGIN   = 4'd5;
    localparam uop_tag_t UOP_BRANCH           = 4'd6;

    function automatic logic is_solo_uop(input uop_tag_t tag);
        return (tag == UOP_CAP_FENCE_PREFIX) ||
               (tag == UOP_CAP_LOAN_BEGIN);
    endfunction

endpackage

// File: rtl/uop_ring.sv
// Circular uop buffer: one push port, pop of 0..2 entries per cycle,
// and two read ports at the head and head+1.
module uop_ring
    import uop_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  uop_tag_t      push_data_i,
    input  logic [1:0]    pop_cnt_i,
    output uop_tag_t      rd0_o,
    output uop_tag_t      rd1_o,
    output logic [AW:0]   occ_o
);

    uop_tag_t        r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_occ;
    logic [AW-1:0]   w_rd1_ptr;

    assign w_rd1_ptr = r_rd_ptr + AW'(1);
    assign rd0_o     = r_mem[r_rd_ptr];
    assign rd1_o     = r_mem[w_rd1_ptr];
    assign occ_o     = r_occ;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(pop_cnt_i);
            r_occ    <= r_occ + (AW+1)'(push_i)
                              - (AW+1)'(pop_cnt_i);
        end
    end

endmodule

// File: rtl/rename_emit_queue.sv
// Rename-to-dispatch emit queue: forms beats of up to two uop tags.
// Two-lane pairing is enabled by defining RENAME_EMIT_DUAL_EN.
module rename_emit_queue
    import uop_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAX_UOPS = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          decode_valid_i,
    input  uop_tag_t      decode_uop_i,
    output logic          decode_ready_o,
    output logic          rename_valid_o,
    output uop_tag_t      rename_uop0_o,
    output uop_tag_t      rename_uop1_o,
    output logic [1:0]    rename_uop_count_o,
    input  logic          dispatch_ready_i,
    output logic [AW:0]   occupancy_o,
    output logic [15:0]   emitted_count_o,
    output logic [15:0]   stall_count_o
);

`ifdef RENAME_EMIT_DUAL_EN
    localparam bit DUAL_BUILD = 1'b1;
`else
    localparam bit DUAL_BUILD = 1'b0;
`endif
    localparam bit        LANE1_EN = DUAL_BUILD && (MAX_UOPS == 2);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO    = (AW+1)'(2);

    uop_tag_t     w_rd0;
    uop_tag_t     w_rd1;
    logic [AW:0]  w_occ;
    logic         w_push;
    logic         w_fire;
    logic         w_lane0_v;
    logic         w_lane1_v;
    logic [1:0]   w_count;
    logic [1:0]   w_pop_cnt;
    logic [15:0]  r_emitted;
    logic [15:0]  r_stalls;

    // Ready looks only at occupancy, so no path from dispatch_ready_i.
    assign decode_ready_o = (w_occ != FULL);
    assign w_push         = decode_valid_i && decode_ready_o;

    uop_ring #(
        .DEPTH       (DEPTH)
    ) u_ring (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (w_push),
        .push_data_i (decode_uop_i),
        .pop_cnt_i   (w_pop_cnt),
        .rd0_o       (w_rd0),
        .rd1_o       (w_rd1),
        .occ_o       (w_occ)
    );

    always_comb begin
        w_lane0_v = (w_occ != '0);
        w_lane1_v = LANE1_EN && (w_occ >= TWO) &&
                    !is_solo_uop(w_rd0) && !is_solo_uop(w_rd1);
        w_count   = 2'd0;
        if (w_lane1_v) begin
            w_count = 2'd2;
        end else if (w_lane0_v) begin
            w_count = 2'd1;
        end
    end

    assign rename_valid_o     = w_lane0_v;
    assign rename_uop_count_o = w_count;
    assign rename_uop0_o      = w_lane0_v ? w_rd0 : '0;
    assign rename_uop1_o      = w_lane1_v ? w_rd1 : '0;

    assign w_fire    = rename_valid_o && dispatch_ready_i;
    assign w_pop_cnt = w_fire ? w_count : 2'd0;

    // A fire in a flush cycle is discarded, so it is not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_emitted <= '0;
            r_stalls  <= '0;
        end else begin
            if (w_fire && !flush_i) begin
                r_emitted <= r_emitted + 16'(w_count);
            end
            if (rename_valid_o && !dispatch_ready_i) begin
                r_stalls <= r_stalls + 16'd1;
            end
        end
    end

    assign occupancy_o     = w_occ;
    assign emitted_count_o = r_emitted;
    assign stall_count_o   = r_stalls;

endmodule
